// File: rtl/game_pkg.sv
// Shared types and constants for the RPG game display path.
// Holds the scene-sequencer state encoding and the well-known scene IDs.
package game_pkg;

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    PEND  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int SCENE_START  = 0;
  localparam int SCENE_MAZE   = 1;
  localparam int SCENE_BATTLE = 2;
  localparam int SCENE_END    = 3;

  localparam int RGB_W = 8;

endpackage

// File: rtl/vs_edge_detect.sv
// Detects the inactive->active transition of the selected vsync.
// i_load reseeds the previous level so a source switch cannot look like an edge.
module vs_edge_detect #(
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  input  logic i_load,
  input  logic i_load_level,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= ~VS_ACTIVE;
    end else begin
      r_prev <= i_load ? i_load_level : i_level;
    end
  end

  assign o_edge = (i_level == VS_ACTIVE) && (r_prev != VS_ACTIVE);

endmodule

// File: rtl/scene_sequencer.sv
// Scene manager and VGA source selector: accepts scene-change requests and
// switches the pixel/sync source only on a frame boundary, then blanks N frames.
module scene_sequencer
  import game_pkg::*;
#(
  parameter int   NUM_SCENES   = 4,
  parameter int   SCENE_W      = 2,
  parameter int   RESET_SCENE  = 0,
  parameter int   BLANK_FRAMES = 2,
  parameter logic VS_ACTIVE    = 1'b0,
  parameter logic HS_ACTIVE    = 1'b0,
  parameter int   TIMEOUT_CYC  = 1048575
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SCENES*RGB_W-1:0] src_rgb,
  input  logic [NUM_SCENES-1:0]       src_hs,
  input  logic [NUM_SCENES-1:0]       src_vs,
  input  logic                        req_valid,
  input  logic [SCENE_W-1:0]          req_scene,
  output logic                        req_ready,
  output logic [RGB_W-1:0]            rgb,
  output logic                        hs,
  output logic                        vs,
  output logic [SCENE_W-1:0]          cur_scene,
  output logic                        switching,
  output logic                        req_err
);

  localparam int               TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       BLANK_INIT = 4'(BLANK_FRAMES);

  state_t             r_state, w_next_state;
  logic [SCENE_W-1:0] r_cur_scene, w_next_cur;
  logic [SCENE_W-1:0] r_target, w_next_target;
  logic [3:0]         r_blank_cnt, w_next_blank;
  logic [TO_W-1:0]    r_to_cnt, w_next_to;
  logic [RGB_W-1:0]   r_rgb, w_sel_rgb;
  logic               r_hs, r_vs, r_req_err, w_next_err;
  logic               w_sel_hs, w_sel_vs, w_tgt_vs;
  logic               w_edge, w_load, w_timeout, w_accept, w_req_bad;

  // Source muxes; only legal scene indices are decoded.
  always_comb begin
    w_sel_rgb = '0;
    w_sel_hs  = ~HS_ACTIVE;
    w_sel_vs  = ~VS_ACTIVE;
    w_tgt_vs  = ~VS_ACTIVE;
    for (int i = 0; i < NUM_SCENES; i++) begin
      if (r_cur_scene == SCENE_W'(i)) begin
        w_sel_rgb = src_rgb[RGB_W*i +: RGB_W];
        w_sel_hs  = src_hs[i];
        w_sel_vs  = src_vs[i];
      end
      if (r_target == SCENE_W'(i)) begin
        w_tgt_vs = src_vs[i];
      end
    end
  end

  vs_edge_detect #(
    .VS_ACTIVE(VS_ACTIVE)
  ) u_vs_edge (
    .clk          (clk),
    .rst          (rst),
    .i_level      (w_sel_vs),
    .i_load       (w_load),
    .i_load_level (w_tgt_vs),
    .o_edge       (w_edge)
  );

  // Handshake: a request transfers on any cycle where req_valid && req_ready;
  // req_ready is high only in SHOW, and the requester holds its request until then.
  assign w_accept  = req_valid && (r_state == SHOW);
  assign w_req_bad = (int'(req_scene) >= NUM_SCENES);
  assign w_timeout = (r_to_cnt == TO_LAST);

  always_comb begin
    w_next_state  = r_state;
    w_next_cur    = r_cur_scene;
    w_next_target = r_target;
    w_next_blank  = r_blank_cnt;
    w_next_to     = r_to_cnt;
    w_next_err    = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      SHOW: begin
        w_next_to = '0;
        if (w_accept) begin
          if (w_req_bad) begin
            w_next_err = 1'b1;
          end else if (req_scene != r_cur_scene) begin
            w_next_target = req_scene;
            w_next_state  = PEND;
          end
        end
      end
      PEND: begin
        if (w_edge || w_timeout) begin
          w_next_cur = r_target;
          w_load     = 1'b1;
          w_next_to  = '0;
          if (BLANK_FRAMES == 0) begin
            w_next_state = SHOW;
          end else begin
            w_next_state = BLANK;
            w_next_blank = BLANK_INIT;
          end
        end else begin
          w_next_to = r_to_cnt + TO_W'(1);
        end
      end
      BLANK: begin
        // A real boundary takes priority; the timeout only fires on a silent source.
        if (w_edge) begin
          w_next_to    = '0;
          w_next_blank = r_blank_cnt - 4'd1;
          if (r_blank_cnt == 4'd1) begin
            w_next_state = SHOW;
          end
        end else if (w_timeout) begin
          w_next_to    = '0;
          w_next_blank = '0;
          w_next_state = SHOW;
        end else begin
          w_next_to = r_to_cnt + TO_W'(1);
        end
      end
      default: begin
        w_next_state = SHOW;
        w_next_to    = '0;
        w_next_blank = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SHOW;
      r_cur_scene <= SCENE_W'(RESET_SCENE);
      r_target    <= SCENE_W'(RESET_SCENE);
      r_blank_cnt <= '0;
      r_to_cnt    <= '0;
      r_req_err   <= 1'b0;
      r_rgb       <= '0;
      r_hs        <= ~HS_ACTIVE;
      r_vs        <= ~VS_ACTIVE;
    end else begin
      r_state     <= w_next_state;
      r_cur_scene <= w_next_cur;
      r_target    <= w_next_target;
      r_blank_cnt <= w_next_blank;
      r_to_cnt    <= w_next_to;
      r_req_err   <= w_next_err;
      r_rgb       <= (r_state == BLANK) ? '0 : w_sel_rgb;
      r_hs        <= w_sel_hs;
      r_vs        <= w_sel_vs;
    end
  end

  assign req_ready = (r_state == SHOW);
  assign switching = (r_state != SHOW);
  assign rgb       = r_rgb;
  assign hs        = r_hs;
  assign vs        = r_vs;
  assign cur_scene = r_cur_scene;
  assign req_err   = r_req_err;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: reset, table vectors, hand-written
// switch/timeout/reset sequences, then random traffic against a reference model.
module tb_scene_sequencer;
  import game_pkg::*;

  localparam int NS  = 4;
  localparam int SW  = 3;
  localparam int BF  = 2;
  localparam int TO  = 100;

  logic            clk;
  logic            rst;
  logic [NS*8-1:0] src_rgb;
  logic [NS-1:0]   src_hs;
  logic [NS-1:0]   src_vs;
  logic            req_valid;
  logic [SW-1:0]   req_scene;
  logic            req_ready;
  logic [7:0]      rgb;
  logic            hs;
  logic            vs;
  logic [SW-1:0]   cur_scene;
  logic            switching;
  logic            req_err;

  int n_tests = 0;
  int n_fail  = 0;

  scene_sequencer #(
    .NUM_SCENES  (NS),
    .SCENE_W     (SW),
    .RESET_SCENE (SCENE_START),
    .BLANK_FRAMES(BF),
    .VS_ACTIVE   (1'b0),
    .HS_ACTIVE   (1'b0),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_rgb  (src_rgb),
    .src_hs   (src_hs),
    .src_vs   (src_vs),
    .req_valid(req_valid),
    .req_scene(req_scene),
    .req_ready(req_ready),
    .rgb      (rgb),
    .hs       (hs),
    .vs       (vs),
    .cur_scene(cur_scene),
    .switching(switching),
    .req_err  (req_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_rgb(input int i, input logic [7:0] v);
    src_rgb[8*i +: 8] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 showing, 1 waiting for a boundary, 2 blanking
  int         m_mode, m_cur, m_target, m_left, m_wait;
  bit         m_prev;
  logic [7:0] m_rgb;
  bit         m_hs, m_vs, m_err;

  task automatic model_reset();
    m_mode = 0; m_cur = SCENE_START; m_target = SCENE_START;
    m_left = 0; m_wait = 0; m_prev = 1'b1;
    m_rgb = 8'h00; m_hs = 1'b1; m_vs = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit sel_vs;
    bit bnd;
    sel_vs = src_vs[m_cur];
    bnd    = (sel_vs == 1'b0) && m_prev;
    m_rgb  = (m_mode == 2) ? 8'h00 : src_rgb[8*m_cur +: 8];
    m_hs   = src_hs[m_cur];
    m_vs   = sel_vs;
    m_err  = 1'b0;
    m_prev = sel_vs;
    if (m_mode == 0) begin
      m_wait = 0;
      if (req_valid) begin
        if (int'(req_scene) >= NS) m_err = 1'b1;
        else if (int'(req_scene) != m_cur) begin
          m_target = int'(req_scene);
          m_mode   = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (bnd || (m_wait + 1 == TO)) begin
        m_cur  = m_target;
        m_prev = src_vs[m_target];
        m_wait = 0;
        m_left = BF;
        m_mode = (BF == 0) ? 0 : 2;
      end else m_wait++;
    end else begin
      if (bnd) begin
        m_wait = 0;
        m_left--;
        if (m_left == 0) m_mode = 0;
      end else if (m_wait + 1 == TO) begin
        m_wait = 0;
        m_mode = 0;
      end else m_wait++;
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0] rgb0;
    logic       hs0;
    logic       vs0;
    logic       rv;
    logic [2:0] rs;
    logic [7:0] exp_rgb;
    logic       exp_hs;
    logic       exp_vs;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1;
    src_rgb = '0; src_hs = '1; src_vs = '1;
    req_valid = 1'b0; req_scene = '0;

    vecs[0] = '{8'hE0, 1'b1, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 1'b0, 1'b1, 1'b1, 3'd5, 8'h5A, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'h33, 1'b1, 1'b0, 1'b0, 3'd0, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b1, 3'd0, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 1'b1, 1'b1, 1'b1, 3'd4, 8'h7F, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 3'd7, 8'h01, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'hE0, 1'b1, 1'b1, 1'b0, 3'd0, 8'hE0, 1'b1, 1'b1, 1'b0};

    // --- reset mid-frame ---
    set_rgb(0, 8'hE0);
    set_rgb(2, 8'h1C);
    #23;
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_hs", hs, 1'b1);
    chk("rst_vs", vs, 1'b1);
    chk("rst_cur", cur_scene, SCENE_START);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_sw", switching, 1'b0);
    chk("rst_err", req_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rel_rgb", rgb, 8'hE0);

    // --- table: output path, invalid and no-op requests ---
    for (int v = 0; v < 8; v++) begin
      set_rgb(0, vecs[v].rgb0);
      src_hs[0] = vecs[v].hs0;
      src_vs[0] = vecs[v].vs0;
      req_valid = vecs[v].rv;
      req_scene = vecs[v].rs;
      tick();
      chk($sformatf("vec%0d_rgb", v), rgb, vecs[v].exp_rgb);
      chk($sformatf("vec%0d_hs", v), hs, vecs[v].exp_hs);
      chk($sformatf("vec%0d_vs", v), vs, vecs[v].exp_vs);
      chk($sformatf("vec%0d_err", v), req_err, vecs[v].exp_err);
      chk($sformatf("vec%0d_sw", v), switching, 1'b0);
      chk($sformatf("vec%0d_cur", v), cur_scene, SCENE_START);
    end
    req_valid = 1'b0;

    // --- switch to battle scene with two blank frames ---
    req_valid = 1'b1; req_scene = SW'(SCENE_BATTLE);
    tick();
    req_valid = 1'b0;
    chk("sw_ready_low", req_ready, 1'b0);
    chk("sw_pend", switching, 1'b1);
    repeat (5) tick();
    chk("sw_pend_rgb", rgb, 8'hE0);
    chk("sw_pend_cur", cur_scene, SCENE_START);
    src_vs[0] = 1'b0;
    tick();
    src_vs[0] = 1'b1;
    chk("sw_cur_new", cur_scene, SCENE_BATTLE);
    tick();
    chk("sw_blank_rgb", rgb, 8'h00);
    src_vs[2] = 1'b0;
    tick();
    src_vs[2] = 1'b1;
    chk("sw_blank1_sw", switching, 1'b1);
    repeat (3) tick();
    chk("sw_blank1_rgb", rgb, 8'h00);
    src_vs[2] = 1'b0;
    tick();
    src_vs[2] = 1'b1;
    chk("sw_done_sw", switching, 1'b0);
    chk("sw_done_ready", req_ready, 1'b1);
    chk("sw_done_rgb", rgb, 8'h00);
    tick();
    chk("sw_show_rgb", rgb, 8'h1C);
    chk("sw_show_cur", cur_scene, SCENE_BATTLE);

    // --- timeout with silent vsync ---
    do_reset();
    src_vs = '1;
    set_rgb(1, 8'h03);
    req_valid = 1'b1; req_scene = SW'(SCENE_MAZE);
    tick();
    req_valid = 1'b0;
    repeat (TO - 1) tick();
    chk("to_before_cur", cur_scene, SCENE_START);
    chk("to_before_sw", switching, 1'b1);
    tick();
    chk("to_at_cur", cur_scene, SCENE_MAZE);
    repeat (TO - 1) tick();
    chk("to_blank_sw", switching, 1'b1);
    tick();
    chk("to_exit_sw", switching, 1'b0);
    tick();
    chk("to_exit_rgb", rgb, 8'h03);

    // --- reset while blanking with one frame left ---
    do_reset();
    set_rgb(0, 8'hE0);
    set_rgb(3, 8'hC3);
    req_valid = 1'b1; req_scene = SW'(SCENE_END);
    tick();
    req_valid = 1'b0;
    src_vs[0] = 1'b0;
    tick();
    src_vs[0] = 1'b1;
    src_vs[3] = 1'b0;
    tick();
    src_vs[3] = 1'b1;
    chk("rb_cur", cur_scene, SCENE_END);
    chk("rb_sw", switching, 1'b1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("rb_async_cur", cur_scene, SCENE_START);
    chk("rb_async_rgb", rgb, 8'h00);
    chk("rb_async_sw", switching, 1'b0);
    chk("rb_async_ready", req_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rb_rel_rgb", rgb, 8'hE0);
    src_vs[3] = 1'b0; src_vs[0] = 1'b0;
    tick();
    src_vs = '1;
    tick();
    chk("rb_after_sw", switching, 1'b0);
    chk("rb_after_cur", cur_scene, SCENE_START);

    // --- random traffic against the model ---
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit was_show;
      for (int s = 0; s < NS; s++) begin
        set_rgb(s, 8'($urandom));
        src_hs[s] = 1'($urandom_range(0, 1));
        if (c < 1500) src_vs[s] = ($urandom_range(0, 5) != 0);
        else          src_vs[s] = ($urandom_range(0, 299) != 0);
      end
      if (!req_valid && ($urandom_range(0, 9) == 0)) begin
        req_valid = 1'b1;
        req_scene = SW'($urandom_range(0, 7));
      end
      was_show = (m_mode == 0);
      model_step();
      tick();
      chk("rnd_rgb", rgb, m_rgb);
      chk("rnd_hs", hs, m_hs);
      chk("rnd_vs", vs, m_vs);
      chk("rnd_cur", cur_scene, m_cur);
      chk("rnd_ready", req_ready, m_mode == 0);
      chk("rnd_sw", switching, m_mode != 0);
      chk("rnd_err", req_err, m_err);
      if (req_valid && was_show) req_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
Parametrised top-level scene manager and VGA source selector for the RPG game. It holds the current scene (start, maze, battle, end, or more), takes scene-change requests through a valid/ready handshake, and switches the VGA source only on a frame boundary. A programmable number of black frames is inserted after each switch, so there is no tearing or sync glitching. It sits between the per-scene renderers and the VGA pins.

Parameters:
NUM_SCENES, 4, number of scene sources (2..16)
SCENE_W, 2, width of scene index; must satisfy 2**SCENE_W >= NUM_SCENES
RESET_SCENE, 0, scene selected after reset
BLANK_FRAMES, 2, black frames output after a switch (0..15)
VS_ACTIVE, 0, active level of vsync
HS_ACTIVE, 0, active level of hsync
TIMEOUT_CYC, 1048575, max cycles to wait for a frame boundary before forcing the switch

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous active-high reset
src_rgb  in  NUM_SCENES*8  packed {r[2:0],g[2:0],b[1:0]} per scene; scene i at [8i+7:8i]
src_hs  in  NUM_SCENES  hsync per scene
src_vs  in  NUM_SCENES  vsync per scene
req_valid  in  1  scene-change request valid
req_scene  in  SCENE_W  requested scene
req_ready  out  1  request can be accepted
rgb  out  8  selected pixel, registered
hs  out  1  selected hsync, registered
vs  out  1  selected vsync, registered
cur_scene  out  SCENE_W  currently displayed scene
switching  out  1  high while in PEND or BLANK
req_err  out  1  one-cycle pulse: accepted request had req_scene >= NUM_SCENES

Behaviour:
- Reset (async, active-high) sets:
  - state=SHOW, cur_scene=RESET_SCENE, target=RESET_SCENE
  - rgb=0, hs=HS_ACTIVE inverted, vs=VS_ACTIVE inverted
  - req_ready=1, switching=0, req_err=0
  - blank counter=0, timeout counter=0, vs_prev=inactive
- Output path: 1-cycle latency. rgb/hs/vs register the sources at index cur_scene. rgb is forced to 0 when state is BLANK.
- Frame boundary: the registered src_vs[cur_scene] goes from inactive to VS_ACTIVE (vs_prev tracks the selected source).
- Handshake:
  - req_ready = (state==SHOW).
  - Transfer occurs when req_valid && req_ready.
  - req_scene >= NUM_SCENES: the request is consumed, req_err pulses next cycle, state stays SHOW.
  - req_scene == cur_scene: consumed as a no-op.
  - Otherwise target<=req_scene and state goes SHOW->PEND.
- State SHOW: normal display.
- State PEND: display continues from the old scene. The timeout counter increments each cycle.
  - On a frame boundary, or when the counter reaches TIMEOUT_CYC:
    - cur_scene<=target
    - vs_prev<=src_vs[target], so the sync change itself causes no false edge
    - timeout counter cleared
    - if BLANK_FRAMES==0, go to SHOW; else go to BLANK with blank counter=BLANK_FRAMES
  - A frame boundary and the timeout in the same cycle are treated as a single switch.
- State BLANK: rgb=0 while syncs come from the new scene.
  - Each frame boundary of the new scene decrements the counter. On the decrement to 0, go to SHOW.
  - The timeout also applies here: TIMEOUT_CYC cycles with no boundary forces SHOW.
- req_valid during PEND/BLANK: not accepted (ready=0). The requester holds the request, and it is taken in the first SHOW cycle.
- Reset mid-PEND or mid-BLANK: immediate return to reset values. A pending target is discarded.
- cur_scene changes in the same cycle as the source switch. The outputs reflect the new source one cycle later.

Decomposition:
- Shared package game_pkg:
  - state encoding SHOW=2'd0, PEND=2'd1, BLANK=2'd2
  - scene IDs SCENE_START=0, SCENE_MAZE=1, SCENE_BATTLE=2, SCENE_END=3
  - RGB_W=8
- One natural sub-module: vs_edge_detect (registered previous level, VS_ACTIVE polarity, synchronous load port for the reseed on switch). It is used once, on the selected vsync.

Test Plan:
1. Reset mid-frame with RESET_SCENE=0, src_rgb scene0=8'hE0 -> rgb=0 during reset; rgb=8'hE0 one cycle after release; cur_scene=0, req_ready=1.
2. In SHOW, request scene 2 (scene2 rgb=8'h1C), BLANK_FRAMES=2 -> req_ready drops; rgb stays scene0 until scene0 vs falls. Then cur_scene=2 and rgb=0 for exactly 2 scene2 frame boundaries, then rgb=8'h1C and req_ready=1.
3. Request scene 5 with NUM_SCENES=4 -> single-cycle req_err=1; state stays SHOW; cur_scene unchanged.
4. Request cur_scene -> consumed; switching stays 0; no blank frames.
5. Scene0 vs held inactive, TIMEOUT_CYC=100, request scene 1 -> switch at cycle 100 after acceptance; switching=1 until the BLANK exit.
6. Assert rst while in BLANK with counter=1 -> cur_scene=RESET_SCENE, rgb=0, state SHOW, and no further blank frames after release.
